// File: rtl/mod_counter.sv
// Parametrised up/down counter with configurable modulus, wrap or saturate at
// the boundaries, parallel load, synchronous clear and boundary event flags.
module mod_counter #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_up,
  input  logic             i_saturate,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_data,
  output logic             o_at_max,
  output logic             o_at_min,
  output logic             o_event,
  output logic             o_sticky
);

  logic [WIDTH-1:0] r_data;
  logic             r_event;
  logic             r_sticky;

  logic [WIDTH-1:0] w_loadClamped;
  logic [WIDTH-1:0] w_nextData;
  logic             w_nextEvent;
  logic             w_atMax;
  logic             w_atMin;

  assign w_atMax       = (r_data == MAX_VALUE);
  assign w_atMin       = (r_data == '0);
  assign w_loadClamped = (i_load_value > MAX_VALUE) ? MAX_VALUE : i_load_value;

  // Boundaries are detected by exact compare, so a modulus below 2**WIDTH-1
  // never relies on natural binary rollover.
  always_comb begin
    w_nextData  = r_data;
    w_nextEvent = 1'b0;
    if (i_enable) begin
      if (i_up) begin
        if (w_atMax) begin
          w_nextEvent = 1'b1;
          w_nextData  = i_saturate ? r_data : '0;
        end else begin
          w_nextData = r_data + WIDTH'(1);
        end
      end else begin
        if (w_atMin) begin
          w_nextEvent = 1'b1;
          w_nextData  = i_saturate ? r_data : MAX_VALUE;
        end else begin
          w_nextData = r_data - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_data   <= '0;
      r_event  <= 1'b0;
      r_sticky <= 1'b0;
    end else if (i_load) begin
      r_data  <= w_loadClamped;
      r_event <= 1'b0;
    end else begin
      r_data   <= w_nextData;
      r_event  <= w_nextEvent;
      r_sticky <= r_sticky | w_nextEvent;
    end
  end

  assign o_data   = r_data;
  assign o_at_max = w_atMax;
  assign o_at_min = w_atMin;
  assign o_event  = r_event;
  assign o_sticky = r_sticky;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a vector table on a WIDTH=4/MAX=9 instance,
// a model-checked full wrap on the default instance, and a MAX_VALUE=0 corner.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default-parameter instance (16 bits, MAX 65535)
  logic        rstA, enA, upA, satA, clrA, ldA;
  logic [15:0] lvA, dataA;
  logic        maxA, minA, evA, stA;

  mod_counter dutA (
    .i_clk(clk), .i_reset(rstA), .i_enable(enA), .i_up(upA), .i_saturate(satA),
    .i_clear(clrA), .i_load(ldA), .i_load_value(lvA),
    .o_data(dataA), .o_at_max(maxA), .o_at_min(minA), .o_event(evA), .o_sticky(stA)
  );

  // Decimal-modulus instance (4 bits, MAX 9)
  logic       rstB, enB, upB, satB, clrB, ldB;
  logic [3:0] lvB, dataB;
  logic       maxB, minB, evB, stB;

  mod_counter #(.WIDTH(4), .MAX_VALUE(4'd9)) dutB (
    .i_clk(clk), .i_reset(rstB), .i_enable(enB), .i_up(upB), .i_saturate(satB),
    .i_clear(clrB), .i_load(ldB), .i_load_value(lvB),
    .o_data(dataB), .o_at_max(maxB), .o_at_min(minB), .o_event(evB), .o_sticky(stB)
  );

  // Degenerate instance with MAX_VALUE 0, sharing the B controls
  logic [1:0] dataZ;
  logic       maxZ, minZ, evZ, stZ;

  mod_counter #(.WIDTH(2), .MAX_VALUE(2'd0)) dutZ (
    .i_clk(clk), .i_reset(rstB), .i_enable(enB), .i_up(upB), .i_saturate(satB),
    .i_clear(clrB), .i_load(ldB), .i_load_value(lvB[1:0]),
    .o_data(dataZ), .o_at_max(maxZ), .o_at_min(minZ), .o_event(evZ), .o_sticky(stZ)
  );

  typedef struct {
    string      tag;
    logic       rst, clr, ld, en, up, sat;
    logic [3:0] lv;
    logic [3:0] expData;
    logic       expEv, expSt;
  } vecT;

  vecT vecs[$];

  // Behavioural reference for dutA
  int mData, mEv, mSt;

  task automatic addVec(input string tag, input logic rst, clr, ld, en, up, sat,
                        input logic [3:0] lv, input logic [3:0] d, input logic ev, st);
    vecT v;
    v.tag = tag; v.rst = rst; v.clr = clr; v.ld = ld; v.en = en; v.up = up;
    v.sat = sat; v.lv = lv; v.expData = d; v.expEv = ev; v.expSt = st;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, clr, ld, en, up, sat, input logic [3:0] lv);
    rstB = rst; clrB = clr; ldB = ld; enB = en; upB = up; satB = sat; lvB = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic stepA(input logic rst, clr, ld, en, up, sat, input logic [15:0] lv);
    rstA = rst; clrA = clr; ldA = ld; enA = en; upA = up; satA = sat; lvA = lv;
    @(posedge clk);
    #1;
    if (rst || clr) begin
      mData = 0; mEv = 0; mSt = 0;
    end else if (ld) begin
      mData = int'(lv); mEv = 0;
    end else begin
      mEv = 0;
      if (en) begin
        if (up) begin
          if (mData == 65535) begin mEv = 1; if (!sat) mData = 0; end
          else mData = mData + 1;
        end else begin
          if (mData == 0) begin mEv = 1; if (!sat) mData = 65535; end
          else mData = mData - 1;
        end
      end
      if (mEv == 1) mSt = 1;
    end
  endtask

  task automatic compareA(input string tag);
    checkOutput({tag, ".data"},   32'(dataA), 32'(mData));
    checkOutput({tag, ".event"},  32'(evA),   32'(mEv));
    checkOutput({tag, ".sticky"}, 32'(stA),   32'(mSt));
    checkOutput({tag, ".at_max"}, 32'(maxA),  32'(mData == 65535));
    checkOutput({tag, ".at_min"}, 32'(minA),  32'(mData == 0));
  endtask

  initial begin
    rstA = 1; enA = 0; upA = 1; satA = 0; clrA = 0; ldA = 0; lvA = '0;
    rstB = 1; enB = 0; upB = 1; satB = 0; clrB = 0; ldB = 0; lvB = '0;

    //      tag        rst clr ld en up sat lv  data ev st
    addVec("reset0",   1,  0,  0, 0, 1, 0,  0,  0,   0, 0);
    addVec("resetLd",  1,  0,  1, 1, 1, 0,  7,  0,   0, 0);
    for (int i = 1; i <= 9; i++)
      addVec("upWrap", 0, 0, 0, 1, 1, 0, 0, 4'(i), 0, 0);
    addVec("wrap9to0", 0,  0,  0, 1, 1, 0,  0,  0,   1, 1);
    addVec("afterWrp", 0,  0,  0, 1, 1, 0,  0,  1,   0, 1);
    addVec("hold",     0,  0,  0, 0, 0, 1,  0,  1,   0, 1);
    addVec("clear",    0,  1,  0, 1, 1, 0,  0,  0,   0, 0);
    addVec("load8",    0,  0,  1, 0, 1, 1,  8,  8,   0, 0);
    addVec("sat1",     0,  0,  0, 1, 1, 1,  0,  9,   0, 0);
    addVec("sat2",     0,  0,  0, 1, 1, 1,  0,  9,   1, 1);
    addVec("sat3",     0,  0,  0, 1, 1, 1,  0,  9,   1, 1);
    for (int i = 8; i >= 0; i--)
      addVec("satDown", 0, 0, 0, 1, 0, 1, 0, 4'(i), 0, 1);
    addVec("satDnHld", 0,  0,  0, 1, 0, 1,  0,  0,   1, 1);
    addVec("load0",    0,  0,  1, 0, 0, 0,  0,  0,   0, 1);
    addVec("dnWrap",   0,  0,  0, 1, 0, 0,  0,  9,   1, 1);
    addVec("ldClamp",  0,  0,  1, 0, 1, 0, 15,  9,   0, 1);
    addVec("ldBeatEn", 0,  0,  1, 1, 1, 0,  3,  3,   0, 1);
    addVec("clrBtLd",  0,  1,  1, 1, 1, 0,  5,  0,   0, 0);
    addVec("idle",     0,  0,  0, 0, 1, 0,  0,  0,   0, 0);
    for (int i = 1; i <= 5; i++)
      addVec("countTo5", 0, 0, 0, 1, 1, 0, 0, 4'(i), 0, 0);
    addVec("midRst1",  1,  0,  0, 1, 1, 0,  0,  0,   0, 0);
    addVec("midRst2",  1,  0,  0, 1, 1, 0,  0,  0,   0, 0);
    for (int i = 1; i <= 3; i++)
      addVec("resume", 0, 0, 0, 1, 1, 0, 0, 4'(i), 0, 0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].clr, vecs[k].ld, vecs[k].en,
                    vecs[k].up, vecs[k].sat, vecs[k].lv);
      checkOutput({vecs[k].tag, ".data"},   32'(dataB), 32'(vecs[k].expData));
      checkOutput({vecs[k].tag, ".event"},  32'(evB),   32'(vecs[k].expEv));
      checkOutput({vecs[k].tag, ".sticky"}, 32'(stB),   32'(vecs[k].expSt));
      checkOutput({vecs[k].tag, ".at_max"}, 32'(maxB),  32'(vecs[k].expData == 4'd9));
      checkOutput({vecs[k].tag, ".at_min"}, 32'(minB),  32'(vecs[k].expData == 4'd0));
    end

    // MAX_VALUE 0: flags always high, every enabled step is a boundary event
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkOutput("z.rst.data", 32'(dataZ), 0);
    checkOutput("z.rst.max",  32'(maxZ), 1);
    checkOutput("z.rst.min",  32'(minZ), 1);
    checkOutput("z.rst.st",   32'(stZ), 0);
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("z.up.data",  32'(dataZ), 0);
    checkOutput("z.up.ev",    32'(evZ), 1);
    checkOutput("z.up.st",    32'(stZ), 1);
    applyStimulus(0, 0, 0, 1, 0, 1, 0);
    checkOutput("z.dn.data",  32'(dataZ), 0);
    checkOutput("z.dn.ev",    32'(evZ), 1);
    applyStimulus(0, 0, 1, 0, 1, 0, 4'd3);
    checkOutput("z.ld.data",  32'(dataZ), 0);
    checkOutput("z.ld.ev",    32'(evZ), 0);
    checkOutput("z.ld.st",    32'(stZ), 1);
    checkOutput("z.ld.max",   32'(maxZ), 1);

    // Default instance: 10 reset cycles, then one full free-running wrap
    for (int i = 0; i < 10; i++) stepA(1, 0, 0, 0, 1, 0, 16'd0);
    compareA("a.reset");
    for (int i = 0; i < 65540; i++) begin
      stepA(0, 0, 0, 1, 1, 0, 16'd0);
      compareA("a.free");
    end

    // Near-top load, then direction and mode flipping on the fly
    stepA(0, 0, 1, 0, 1, 0, 16'd65533);
    compareA("a.load");
    for (int i = 0; i < 24; i++) begin
      stepA(0, 0, 0, (i % 7) != 6, (i < 6) || (i >= 16), (i % 4) < 2, 16'd0);
      compareA("a.mixed");
    end
    stepA(0, 1, 0, 1, 1, 0, 16'd0);
    compareA("a.clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
